descrambler_64b66b_rx: RTL

- Receive-side counterpart of the 64b/66b transmit scrambler. Polynomial x^58 + x^39 + 1, self-synchronizing, 64-bit parallel.
- Takes 66-bit blocks (2-bit sync header plus 64-bit scrambled payload) from the RX gearbox and descrambles the payload.
- Runs the sync-header block-lock state machine and drives a bit-slip request back to the gearbox.
- Output feeds the 64b/66b decoder.

---
 rtl/descrambler_64b66b_rx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/descrambler_64b66b_rx.sv
// 64b/66b receive descrambler (x^58 + x^39 + 1, self-synchronizing) with
// sync-header block-lock state machine and gearbox bit-slip request.
module descrambler_64b66b_rx #(
  parameter int unsigned LOCK_CNT  = 64,
  parameter int unsigned ERR_LIMIT = 16,
  parameter int unsigned WINDOW    = 64,
  parameter int unsigned SLIP_WAIT = 4
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [1:0]  rx_header,
  input  logic [63:0] rx_data,
  output logic        out_valid,
  output logic [1:0]  out_header,
  output logic [63:0] out_data,
  output logic        hdr_err,
  output logic        block_lock,
  output logic        slip
);

  localparam int unsigned SH_W   = $clog2(LOCK_CNT + 1);
  localparam int unsigned ERR_W  = $clog2(ERR_LIMIT + 1);
  localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SLIP   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]        state, state_nx;
  logic [SH_W-1:0]   sh_cnt, sh_nx, sh_inc;
  logic [ERR_W-1:0]  err_cnt, err_nx, err_inc;
  logic [WIN_W-1:0]  win_cnt, win_nx, win_inc;
  logic [WAIT_W-1:0] wait_cnt, wait_nx, wait_inc;
  logic              slip_nx;
  logic [57:0]       prev;
  logic [121:0]      ext_c;
  logic [63:0]       desc_c;
  logic              hdr_ok_c;
  logic              emit_c;

  // Previous scrambled bits sit below the current word so taps index one vector
  assign ext_c    = {rx_data, prev};
  assign hdr_ok_c = rx_header[1] ^ rx_header[0];
  assign emit_c   = rx_valid && (state == ST_LOCKED);

  always_comb begin
    desc_c = '0;
    for (int i = 0; i < 64; i++) begin
      desc_c[i] = ext_c[58 + i] ^ ext_c[i + 19] ^ ext_c[i];
    end
  end

  assign sh_inc   = sh_cnt + SH_W'(1);
  assign wait_inc = wait_cnt + WAIT_W'(1);
  assign win_inc  = win_cnt + WIN_W'(1);
  assign err_inc  = err_cnt + ERR_W'(!hdr_ok_c);

  // Block-lock next state; advances only on valid blocks
  always_comb begin
    state_nx = state;
    sh_nx    = sh_cnt;
    err_nx   = err_cnt;
    win_nx   = win_cnt;
    wait_nx  = wait_cnt;
    slip_nx  = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_HUNT: begin
          if (!hdr_ok_c) begin
            state_nx = ST_SLIP;
            sh_nx    = '0;
            wait_nx  = '0;
            slip_nx  = 1'b1;
          end else if (sh_inc == SH_W'(LOCK_CNT)) begin
            state_nx = ST_LOCKED;
            sh_nx    = '0;
            win_nx   = '0;
            err_nx   = '0;
          end else begin
            sh_nx = sh_inc;
          end
        end
        ST_SLIP: begin
          if (wait_inc == WAIT_W'(SLIP_WAIT)) begin
            state_nx = ST_HUNT;
            wait_nx  = '0;
            sh_nx    = '0;
          end else begin
            wait_nx = wait_inc;
          end
        end
        ST_LOCKED: begin
          // Loss of lock takes priority over a window rollover on the same block
          if (err_inc == ERR_W'(ERR_LIMIT)) begin
            state_nx = ST_SLIP;
            slip_nx  = 1'b1;
            win_nx   = '0;
            err_nx   = '0;
            wait_nx  = '0;
            sh_nx    = '0;
          end else if (win_inc == WIN_W'(WINDOW)) begin
            win_nx = '0;
            err_nx = '0;
          end else begin
            win_nx = win_inc;
            err_nx = err_inc;
          end
        end
        default: begin
          state_nx = ST_HUNT;
          sh_nx    = '0;
          err_nx   = '0;
          win_nx   = '0;
          wait_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_HUNT;
      sh_cnt   <= '0;
      err_cnt  <= '0;
      win_cnt  <= '0;
      wait_cnt <= '0;
      prev     <= '0;
    end else begin
      state    <= state_nx;
      sh_cnt   <= sh_nx;
      err_cnt  <= err_nx;
      win_cnt  <= win_nx;
      wait_cnt <= wait_nx;
      if (rx_valid) prev <= rx_data[63:6];
    end
  end

  // Registered outputs
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_header <= '0;
      out_data   <= '0;
      hdr_err    <= 1'b0;
      block_lock <= 1'b0;
      slip       <= 1'b0;
    end else begin
      out_valid  <= emit_c;
      hdr_err    <= emit_c && !hdr_ok_c;
      block_lock <= (state_nx == ST_LOCKED);
      slip       <= slip_nx;
      if (emit_c) begin
        out_header <= rx_header;
        out_data   <= desc_c;
      end
    end
  end

endmodule
